// File: rtl/uart_periph.sv
// Device-side UART peripheral: host register port, TX/RX FIFOs and an 8N1
// serializer/deserializer driving txd and sampling rxd (LSB first).
module uart_periph #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rd,
    input  logic              uart_wr,
    input  logic [1:0]        uart_addr,
    input  logic [DATA_W-1:0] uart_din,
    output logic [DATA_W-1:0] uart_dout,
    output logic [DATA_W-1:0] uart_dout1,
    input  logic              rxd,
    output logic              txd
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLK_DIV);
    localparam int NW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(CLK_DIV / 2 - 1);
    localparam logic [NW-1:0] BIT_LAST  = NW'(DATA_W - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Host access decode
    logic host_tx_wr;
    logic host_clr;
    logic host_rx_rd;

    // TX FIFO
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]     tx_wp;
    logic [AW-1:0]     tx_rp;
    logic [CW-1:0]     tx_count;
    logic              tx_full;
    logic              tx_push;
    logic              tx_pop;

    // TX FSM
    state_t            tx_state;
    logic [BW-1:0]     tx_baud;
    logic [NW-1:0]     tx_bit;
    logic [DATA_W-1:0] tx_shift;

    // RX synchronizer and FSM
    logic              rx_p0;
    logic              rx_p1;
    logic              rx_p2;
    logic              rs;
    state_t            rx_state;
    logic [BW-1:0]     rx_baud;
    logic [NW-1:0]     rx_bit;
    logic [DATA_W-1:0] rx_shift;
    logic              rx_wait;
    logic              rx_push;
    logic              rx_bad;

    // RX FIFO
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]     rx_wp;
    logic [AW-1:0]     rx_rp;
    logic [CW-1:0]     rx_count;
    logic              rx_full;
    logic              rx_push_ok;

    // Sticky flags and status
    logic              rx_ovf;
    logic              frame_err;
    logic              tx_ovf;
    logic              tx_idle;
    logic              rx_avail;

    // A simultaneous write wins over a read, whatever the write address.
    assign host_tx_wr = uart_wr && (uart_addr == 2'd0);
    assign host_clr   = uart_wr && (uart_addr == 2'd3);
    assign host_rx_rd = uart_rd && !uart_wr && (uart_addr == 2'd0) && (rx_count != '0);

    assign tx_full = (tx_count == FULL_CNT);
    assign tx_pop  = (tx_state == IDLE) && (tx_count != '0);
    assign tx_push = host_tx_wr && (!tx_full || tx_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + AW'(1);
            if (tx_pop)  tx_rp <= tx_rp + AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + CW'(1);
                2'b01:   tx_count <= tx_count - CW'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= uart_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= IDLE;
            tx_baud  <= '0;
            tx_bit   <= '0;
            txd      <= 1'b1;
        end else begin
            case (tx_state)
                IDLE: begin
                    txd <= 1'b1;
                    if (tx_pop) begin
                        tx_shift <= tx_mem[tx_rp];
                        txd      <= 1'b0;
                        tx_baud  <= '0;
                        tx_state <= START;
                    end
                end
                START: begin
                    if (tx_baud == BAUD_LAST) begin
                        tx_baud  <= '0;
                        tx_bit   <= '0;
                        txd      <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_state <= DATA;
                    end else begin
                        tx_baud <= tx_baud + BW'(1);
                    end
                end
                DATA: begin
                    if (tx_baud == BAUD_LAST) begin
                        tx_baud <= '0;
                        if (tx_bit == BIT_LAST) begin
                            txd      <= 1'b1;
                            tx_state <= STOP;
                        end else begin
                            tx_bit   <= tx_bit + NW'(1);
                            txd      <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
                    end else begin
                        tx_baud <= tx_baud + BW'(1);
                    end
                end
                STOP: begin
                    if (tx_baud == BAUD_LAST) begin
                        tx_baud  <= '0;
                        tx_state <= IDLE;
                    end else begin
                        tx_baud <= tx_baud + BW'(1);
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // rx_p2 is the previous synchronized value, used for start-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
            rx_p2 <= 1'b1;
        end else begin
            rx_p0 <= rxd;
            rx_p1 <= rx_p0;
            rx_p2 <= rx_p1;
        end
    end

    assign rs = rx_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= IDLE;
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_wait  <= 1'b0;
            rx_push  <= 1'b0;
            rx_bad   <= 1'b0;
        end else begin
            rx_push <= 1'b0;
            rx_bad  <= 1'b0;
            case (rx_state)
                IDLE: begin
                    rx_wait <= 1'b0;
                    if (rx_p2 && !rs) begin
                        rx_baud  <= '0;
                        rx_state <= START;
                    end
                end
                START: begin
                    if (rx_baud == BAUD_HALF) begin
                        rx_baud  <= '0;
                        rx_bit   <= '0;
                        rx_state <= rs ? IDLE : DATA;
                    end else begin
                        rx_baud <= rx_baud + BW'(1);
                    end
                end
                DATA: begin
                    if (rx_baud == BAUD_LAST) begin
                        rx_baud  <= '0;
                        rx_shift <= {rs, rx_shift[DATA_W-1:1]};
                        if (rx_bit == BIT_LAST) rx_state <= STOP;
                        else                    rx_bit   <= rx_bit + NW'(1);
                    end else begin
                        rx_baud <= rx_baud + BW'(1);
                    end
                end
                STOP: begin
                    if (rx_wait) begin
                        // Broken frame: hold until the line returns high
                        if (rs) begin
                            rx_wait  <= 1'b0;
                            rx_state <= IDLE;
                        end
                    end else if (rx_baud == BAUD_LAST) begin
                        rx_baud <= '0;
                        if (rs) begin
                            rx_push  <= 1'b1;
                            rx_state <= IDLE;
                        end else begin
                            rx_bad  <= 1'b1;
                            rx_wait <= 1'b1;
                        end
                    end else begin
                        rx_baud <= rx_baud + BW'(1);
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    // A full FIFO still accepts a character when the host pops in the same cycle
    assign rx_full    = (rx_count == FULL_CNT);
    assign rx_push_ok = rx_push && (!rx_full || host_rx_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push_ok) rx_wp <= rx_wp + AW'(1);
            if (host_rx_rd) rx_rp <= rx_rp + AW'(1);
            case ({rx_push_ok, host_rx_rd})
                2'b10:   rx_count <= rx_count + CW'(1);
                2'b01:   rx_count <= rx_count - CW'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push_ok) rx_mem[rx_wp] <= rx_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ovf    <= 1'b0;
            frame_err <= 1'b0;
            tx_ovf    <= 1'b0;
        end else begin
            if (host_clr && uart_din[0]) rx_ovf <= 1'b0;
            if (rx_push && rx_full && !host_rx_rd) rx_ovf <= 1'b1;
            if (host_clr && uart_din[1]) frame_err <= 1'b0;
            if (rx_bad) frame_err <= 1'b1;
            if (host_clr && uart_din[2]) tx_ovf <= 1'b0;
            if (host_tx_wr && tx_full && !tx_pop) tx_ovf <= 1'b1;
        end
    end

    assign rx_avail   = (rx_count != '0);
    assign tx_idle    = (tx_count == '0) && (tx_state == IDLE);
    assign uart_dout  = rx_avail ? rx_mem[rx_rp] : '0;
    assign uart_dout1 = DATA_W'({tx_ovf, frame_err, rx_ovf, tx_idle, tx_full, rx_avail});

endmodule

// File: tb/tb_uart_periph.sv
// Directed bench for uart_periph with CLK_DIV=4 and FIFO_DEPTH=4; outputs are
// sampled on the falling clock edge, inputs change there too.
module tb_uart_periph;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int DATA_W     = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rd;
    logic       uart_wr;
    logic [1:0] uart_addr;
    logic [7:0] uart_din;
    logic [7:0] uart_dout;
    logic [7:0] uart_dout1;
    logic       rxd;
    logic       txd;

    int errors = 0;
    int checks = 0;

    uart_periph #(
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH),
        .DATA_W    (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rd   (uart_rd),
        .uart_wr   (uart_wr),
        .uart_addr (uart_addr),
        .uart_din  (uart_din),
        .uart_dout (uart_dout),
        .uart_dout1(uart_dout1),
        .rxd       (rxd),
        .txd       (txd)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        uart_wr = 1'b1; uart_addr = a; uart_din = d;
        @(negedge clk);
        uart_wr = 1'b0;
    endtask

    task automatic host_read();
        @(negedge clk);
        uart_rd = 1'b1; uart_addr = 2'd0;
        @(negedge clk);
        uart_rd = 1'b0;
    endtask

    // Serial frame driven on rxd: start, 8 data LSB first, given stop level
    task automatic send_rx(input logic [7:0] d, input logic stop);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rxd = fr[k];
            repeat (CLK_DIV) @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    // Waits (bounded) for a start bit, then records 40 per-cycle txd samples
    task automatic capture_frame(output logic [39:0] samp, output bit found);
        found = 1'b0;
        samp  = '1;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (txd === 1'b0) found = 1'b1;
        end
        if (found) begin
            samp[0] = 1'b0;
            for (int i = 1; i < 40; i++) begin
                @(negedge clk);
                samp[i] = txd;
            end
        end
    endtask

    function automatic logic [7:0] decode(input logic [39:0] s);
        logic [7:0] d;
        for (int b = 0; b < 8; b++) d[b] = s[4*(b+1)+1];
        return d;
    endfunction

    function automatic bit framed(input logic [39:0] s);
        return (s[3:0] === 4'h0) && (s[39:36] === 4'hF);
    endfunction

    task automatic test_reset();
        rst = 1'b1; rxd = 1'b1; uart_rd = 1'b0; uart_wr = 1'b0;
        uart_addr = 2'd0; uart_din = 8'h00;
        idle(3);
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got=%b want=1", txd); end
        checks++; if (uart_dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h want=00", uart_dout); end
        checks++; if (uart_dout1 !== 8'h04) begin errors++; $display("FAIL reset_status got=%h want=04", uart_dout1); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_tx_single();
        logic [39:0] samp;
        bit          found;
        logic        exp_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        host_write(2'd0, 8'hA5);
        checks++; if (uart_dout1[2] !== 1'b0) begin errors++; $display("FAIL tx_busy_idle got=%b want=0", uart_dout1[2]); end
        capture_frame(samp, found);
        checks++;
        if (!found) begin
            errors++; $display("FAIL tx_single_start got=none want=start_bit");
        end else begin
            for (int k = 0; k < 10; k++) begin
                checks++;
                if (samp[4*k +: 4] !== {4{exp_bits[k]}}) begin
                    errors++;
                    $display("FAIL tx_single_bit%0d got=%b want=%b", k, samp[4*k +: 4], {4{exp_bits[k]}});
                end
            end
        end
        idle(1);
        checks++; if (uart_dout1 !== 8'h04) begin errors++; $display("FAIL tx_single_done got=%h want=04", uart_dout1); end
    endtask

    task automatic test_tx_overflow();
        logic [7:0] got [5];
        bit         ok  [5];
        int         lows;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    uart_wr = 1'b1; uart_addr = 2'd0; uart_din = 8'(i + 1);
                end
                @(negedge clk);
                uart_wr = 1'b0;
            end
            begin
                for (int f = 0; f < 5; f++) begin
                    logic [39:0] s;
                    bit          fnd;
                    capture_frame(s, fnd);
                    got[f] = decode(s);
                    ok[f]  = fnd && framed(s);
                end
            end
        join
        for (int f = 0; f < 5; f++) begin
            checks++;
            if (!ok[f] || got[f] !== 8'(f + 1)) begin
                errors++;
                $display("FAIL tx_ovf_byte%0d got=%h framed=%0d want=%h", f, got[f], ok[f], 8'(f + 1));
            end
        end
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        checks++; if (lows != 0) begin errors++; $display("FAIL tx_ovf_dropped got=%0d_low_cycles want=0", lows); end
        checks++; if (uart_dout1 !== 8'h24) begin errors++; $display("FAIL tx_ovf_flag got=%h want=24", uart_dout1); end
        host_write(2'd3, 8'h04);
        checks++; if (uart_dout1 !== 8'h04) begin errors++; $display("FAIL tx_ovf_clear got=%h want=04", uart_dout1); end
    endtask

    task automatic test_rx_single();
        send_rx(8'h3C, 1'b1);
        idle(4);
        checks++; if (uart_dout1[0] !== 1'b1) begin errors++; $display("FAIL rx_avail got=%b want=1", uart_dout1[0]); end
        checks++; if (uart_dout !== 8'h3C) begin errors++; $display("FAIL rx_data got=%h want=3C", uart_dout); end
        host_read();
        checks++; if (uart_dout1[0] !== 1'b0) begin errors++; $display("FAIL rx_pop_avail got=%b want=0", uart_dout1[0]); end
        checks++; if (uart_dout !== 8'h00) begin errors++; $display("FAIL rx_pop_data got=%h want=00", uart_dout); end
    endtask

    task automatic test_rx_errors();
        @(negedge clk);
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        idle(12);
        checks++; if (uart_dout1 !== 8'h04) begin errors++; $display("FAIL rx_glitch got=%h want=04", uart_dout1); end
        send_rx(8'h55, 1'b0);
        idle(6);
        checks++; if (uart_dout1 !== 8'h14) begin errors++; $display("FAIL rx_frame_err got=%h want=14", uart_dout1); end
        idle(10);
        checks++; if (uart_dout1[4] !== 1'b1) begin errors++; $display("FAIL rx_frame_sticky got=%b want=1", uart_dout1[4]); end
        host_write(2'd3, 8'h02);
        checks++; if (uart_dout1 !== 8'h04) begin errors++; $display("FAIL rx_frame_clear got=%h want=04", uart_dout1); end
    endtask

    task automatic test_rx_overflow();
        logic [7:0] first  [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic [7:0] second [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        for (int i = 0; i < 5; i++) begin
            send_rx(first[i], 1'b1);
            idle(4);
        end
        checks++; if (uart_dout1 !== 8'h0D) begin errors++; $display("FAIL rx_ovf_flag got=%h want=0D", uart_dout1); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (uart_dout !== first[i]) begin errors++; $display("FAIL rx_ovf_data%0d got=%h want=%h", i, uart_dout, first[i]); end
            host_read();
        end
        checks++; if (uart_dout1 !== 8'h0C) begin errors++; $display("FAIL rx_ovf_drained got=%h want=0C", uart_dout1); end
        host_write(2'd3, 8'h01);
        checks++; if (uart_dout1 !== 8'h04) begin errors++; $display("FAIL rx_ovf_clear got=%h want=04", uart_dout1); end
        for (int i = 0; i < 4; i++) begin
            send_rx(second[i], 1'b1);
            idle(4);
        end
        checks++; if (uart_dout1 !== 8'h05) begin errors++; $display("FAIL rx_full got=%h want=05", uart_dout1); end
        // Read strobe lands on the same edge the fifth character is pushed
        send_rx(second[4], 1'b1);
        host_read();
        idle(2);
        checks++; if (uart_dout1 !== 8'h05) begin errors++; $display("FAIL rx_pushpop_status got=%h want=05", uart_dout1); end
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (uart_dout !== second[i]) begin errors++; $display("FAIL rx_pushpop_data%0d got=%h want=%h", i, uart_dout, second[i]); end
            host_read();
        end
        checks++; if (uart_dout1 !== 8'h04) begin errors++; $display("FAIL rx_pushpop_count got=%h want=04", uart_dout1); end
    endtask

    task automatic test_reset_midframe();
        bit found;
        int lows;
        send_rx(8'h42, 1'b1);
        idle(4);
        host_write(2'd0, 8'h5A);
        host_write(2'd0, 8'h77);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (txd === 1'b0) found = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL rst_mid_start got=none want=start_bit"); end
        idle(10);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rst_mid_txd got=%b want=1", txd); end
        checks++; if (uart_dout1 !== 8'h04) begin errors++; $display("FAIL rst_mid_status got=%h want=04", uart_dout1); end
        checks++; if (uart_dout !== 8'h00) begin errors++; $display("FAIL rst_mid_dout got=%h want=00", uart_dout); end
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        checks++; if (lows != 0) begin errors++; $display("FAIL rst_mid_resumed got=%0d_low_cycles want=0", lows); end
    endtask

    task automatic test_collision();
        logic [39:0] samp;
        bit          found;
        send_rx(8'h96, 1'b1);
        idle(4);
        @(negedge clk);
        uart_rd = 1'b1; uart_wr = 1'b1; uart_addr = 2'd0; uart_din = 8'hC3;
        @(negedge clk);
        uart_rd = 1'b0; uart_wr = 1'b0;
        checks++; if (uart_dout !== 8'h96) begin errors++; $display("FAIL coll_no_pop got=%h want=96", uart_dout); end
        capture_frame(samp, found);
        checks++;
        if (!found || !framed(samp) || decode(samp) !== 8'hC3) begin
            errors++; $display("FAIL coll_tx_byte got=%h framed=%0d want=C3", decode(samp), found && framed(samp));
        end
        idle(2);
        checks++; if (uart_dout1 !== 8'h05) begin errors++; $display("FAIL coll_status got=%h want=05", uart_dout1); end
        host_read();
        checks++; if (uart_dout1 !== 8'h04) begin errors++; $display("FAIL coll_final got=%h want=04", uart_dout1); end
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_tx_overflow();
        test_rx_single();
        test_rx_errors();
        test_rx_overflow();
        test_reset_midframe();
        test_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_periph.md
Name: uart_periph

Overview:
- Device-side UART peripheral that answers the host-side UART port driven by the core-sharing UART controller (uart_rd / uart_wr / uart_addr / uart_din in; uart_dout / uart_dout1 out).
- Holds a TX FIFO and a TX serializer, plus an RX deserializer and an RX FIFO.
- Drives the txd line and samples the rxd line, using 8N1 framing with the LSB sent first.
- Sits at the top level, between the UART controller port and the board pins.

Parameters:
- CLK_DIV, 434: clock cycles per bit (50 MHz / 115200); minimum 4.
- FIFO_DEPTH, 16: entries per FIFO; must be a power of 2.
- DATA_W, 8: character width; equals the UART data width define.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- uart_rd  in  1  host read strobe; one access per cycle while high.
- uart_wr  in  1  host write strobe; one access per cycle while high.
- uart_addr  in  2  register select.
- uart_din  in  DATA_W  host write data.
- uart_dout  out  DATA_W  RX FIFO head; first-word-fall-through.
- uart_dout1  out  DATA_W  status register.
- rxd  in  1  serial input; asynchronous to clk.
- txd  out  1  serial output.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset effects (all take effect on the first clk edge with rst=1, including mid-frame):
  - txd=1.
  - Both FIFOs empty; all sticky flags cleared.
  - TX and RX state machines return to IDLE.
  - uart_dout=0; uart_dout1=8'h04.
- Register map:
  - Write addr 0: push uart_din into TX FIFO. If the TX FIFO is full, drop the data and set tx_ovf.
  - Read addr 0: pop the RX FIFO. uart_dout shows the next entry on the following cycle. A read while empty is ignored.
  - Write addr 3: din[0]=1 clears rx_ovf; din[1]=1 clears frame_err; din[2]=1 clears tx_ovf.
  - Writes to addr 1/2 and reads other than addr 0 have no side effects.
  - rd and wr high in the same cycle: the write is performed, the read is ignored.
- uart_dout: the RX FIFO head when the FIFO is non-empty, 0 when it is empty. Combinational from registered FIFO state.
- uart_dout1 bit map:
  - [0] rx_avail
  - [1] tx_full
  - [2] tx_idle (TX FIFO empty and TX FSM in IDLE)
  - [3] rx_ovf
  - [4] frame_err
  - [5] tx_ovf
  - [7:6] 0
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: when the FIFO is non-empty, pop into the shift register and enter START on the next cycle.
  - START: txd=0 for CLK_DIV cycles.
  - DATA: DATA_W bits, LSB first, CLK_DIV cycles each.
  - STOP: txd=1 for CLK_DIV cycles, then IDLE.
  - Back-to-back characters have no idle gap beyond the single IDLE cycle.
- RX synchronisation: rxd passes through a 2-flop synchronizer; the FSM uses the synchronized value rs.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE: a falling edge on rs enters START.
  - START: after CLK_DIV/2 cycles, if rs=0 enter DATA; else return to IDLE (glitch reject).
  - DATA: sample every CLK_DIV cycles (mid-bit), shifting right.
  - STOP: sample after CLK_DIV cycles.
    - rs=1: push the character. If the FIFO is full, drop it and set rx_ovf.
    - rs=0: discard the character, set frame_err, and wait in STOP until rs=1 before returning to IDLE.
- RX FIFO push and host pop in the same cycle while full: both succeed, count unchanged, no overflow.
- TX pop by the FSM and host push in the same cycle while full: both succeed.
- FIFO counters are log2(FIFO_DEPTH)+1 bits wide; pointers wrap modulo FIFO_DEPTH.
- Baud counter: counts 0..CLK_DIV-1 and restarts on every state entry.

Test Plan:
1. Single TX character (CLK_DIV=4): write addr0 0xA5.
   - txd sequence: 0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1.
   - status[2] returns to 1 after the stop bit.
2. TX overflow (FIFO_DEPTH=4): write 6 bytes back-to-back 0x01..0x06.
   - 0x01–0x05 are transmitted in order; 0x06 is dropped.
   - tx_ovf=1; writing addr3 din=0x04 clears it.
3. Single RX character: drive rxd with the 8N1 frame for 0x3C.
   - Two synchronizer cycles after the stop-bit sample: status[0]=1 and uart_dout=0x3C.
   - Read addr0: status[0]=0 and uart_dout=0 the next cycle.
4. RX error cases:
   - 1-cycle low glitch on rxd: no push and no flags set.
   - Frame with stop bit 0: nothing pushed; frame_err=1 until a write to addr3 with din=0x02.
5. RX overflow with simultaneous pop (FIFO_DEPTH=4):
   - Receive 5 bytes with no reads: rx_ovf=1, and the FIFO holds bytes 1–4.
   - Fill to full again, then read in the same cycle as a push: count stays 4 and rx_ovf is not newly set.
6. Reset mid-frame and rd/wr collision:
   - Assert rst during TX DATA: txd=1 and status=0x04 after one clk; the interrupted character is never resumed.
   - rd and wr high together at addr0: the TX byte is queued and the RX FIFO is not popped.
